// File: rtl/mul_issue_ctrl_pkg.sv
// Shared definitions for the multiplier issue controller.
//   state_e          : controller state encoding
//   REG_ADDR_W       : register-file address width (rd)
//   DEFAULT_DATA_W   : default operand/result width
//   DEFAULT_TIMEOUT  : default WAIT watchdog limit in cycles
package mul_issue_ctrl_pkg;

    localparam int REG_ADDR_W      = 5;
    localparam int DEFAULT_DATA_W  = 32;
    localparam int DEFAULT_TIMEOUT = 40;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DRAIN,
        ST_WB
    } state_e;

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Bundle of all non-clock/reset signals between the EX stage, the sequential
// multiplier, the writeback port and the issue controller.
//   master : controller view (drives stall, mul_*, wb_*, err)
//   slave  : environment view (EX stage, multiplier, writeback)
interface mul_issue_ctrl_if
    import mul_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);
    // EX stage
    logic                  ex_valid;
    logic                  ex_is_mul;
    logic [DATA_W-1:0]     ex_op_a;
    logic [DATA_W-1:0]     ex_op_b;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  flush;
    logic                  stall;
    // Multiplier
    logic                  mul_start;
    logic [DATA_W-1:0]     mul_a;
    logic [DATA_W-1:0]     mul_b;
    logic                  mul_busy;
    logic                  mul_done;
    logic [DATA_W-1:0]     mul_result;
    // Writeback
    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0]     wb_data;
    logic                  wb_ready;
    // Status
    logic                  err;

    modport master (
        input  ex_valid, ex_is_mul, ex_op_a, ex_op_b, ex_rd, flush,
        input  mul_busy, mul_done, mul_result, wb_ready,
        output stall, mul_start, mul_a, mul_b, wb_valid, wb_rd, wb_data, err
    );

    modport slave (
        output ex_valid, ex_is_mul, ex_op_a, ex_op_b, ex_rd, flush,
        output mul_busy, mul_done, mul_result, wb_ready,
        input  stall, mul_start, mul_a, mul_b, wb_valid, wb_rd, wb_data, err
    );

endinterface

// File: rtl/mul_issue_ctrl_trivial_detect.sv
// Combinational short-circuit detection for multiplies that need no
// multiplier: any zero operand gives 0, an operand of one gives the other.
//   op_a_i, op_b_i : operands
//   hit_o          : operands are trivial
//   result_o       : product for trivial operands (0 when no hit)
module mul_trivial_detect #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] result_o
);

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        hit_o    = 1'b1;
        result_o = '0;
        if (op_a_i == '0 || op_b_i == '0) begin
            result_o = '0;
        end else if (op_b_i == ONE) begin
            result_o = op_a_i;
        end else if (op_a_i == ONE) begin
            result_o = op_b_i;
        end else begin
            hit_o = 1'b0;
        end
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Execute-stage front end for a sequential multiplier. Captures a MUL,
// short-circuits trivial operands, pulses the multiplier start, stalls the
// pipeline until the product is accepted on the writeback port, drains an
// in-flight multiply after a flush, and raises a sticky watchdog error.
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : controller side of mul_issue_ctrl_if (EX, multiplier, writeback)
module mul_issue_ctrl
    import mul_issue_ctrl_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    mul_issue_ctrl_if.master bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  mul_start_q;
    logic [DATA_W-1:0]     mul_a_q;
    logic [DATA_W-1:0]     mul_b_q;
    logic                  wb_valid_q;
    logic [REG_ADDR_W-1:0] wb_rd_q;
    logic [DATA_W-1:0]     wb_data_q;
    logic                  err_q;

    logic                  req;
    logic                  triv_hit;
    logic [DATA_W-1:0]     triv_result;
    logic                  timeout_hit;

    mul_trivial_detect #(.DATA_W(DATA_W)) u_trivial (
        .op_a_i   (bus.ex_op_a),
        .op_b_i   (bus.ex_op_b),
        .hit_o    (triv_hit),
        .result_o (triv_result)
    );

    assign req         = bus.ex_valid & bus.ex_is_mul & ~bus.flush;
    // Compare with >= so a counter that somehow passes the limit still exits.
    assign timeout_hit = (cnt_q >= CNT_W'(TIMEOUT - 1));

    // Stall drops in the accepting WB cycle so the pipeline advances on the
    // same edge the product is taken. While draining a killed multiply any
    // new MUL is held off, flushed or not.
    assign bus.stall = (req & ~((state_q == ST_WB) & bus.wb_ready))
                     | ((state_q == ST_DRAIN) & bus.ex_valid & bus.ex_is_mul);

    assign bus.mul_start = mul_start_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.err       = err_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        wb_rd_q <= bus.ex_rd;
                        if (triv_hit) begin
                            wb_data_q  <= triv_result;
                            wb_valid_q <= 1'b1;
                            state_q    <= ST_WB;
                        end else begin
                            mul_a_q     <= bus.ex_op_a;
                            mul_b_q     <= bus.ex_op_b;
                            mul_start_q <= 1'b1;
                            state_q     <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (mul_start_q && !bus.mul_busy) begin
                        // The start pulse is on the wire this cycle.
                        mul_start_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= ST_WAIT;
                    end else if (bus.mul_busy) begin
                        // Multiplier unexpectedly busy: hold off the pulse.
                        mul_start_q <= 1'b0;
                    end else begin
                        mul_start_q <= 1'b1;
                    end
                end

                ST_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (bus.mul_done) begin
                        wb_data_q  <= bus.mul_result;
                        wb_valid_q <= 1'b1;
                        state_q    <= ST_WB;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (bus.flush) begin
                        state_q <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    // The killed product is discarded when it arrives.
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (bus.mul_done) begin
                        state_q <= ST_IDLE;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end

                ST_WB: begin
                    // Accept beats flush: the result was committed first.
                    if (bus.wb_ready || bus.flush) begin
                        wb_valid_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
module tb_mul_issue_ctrl;

    localparam int DW  = 32;
    localparam int TMO = 40;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mul_issue_ctrl_if #(.DATA_W(DW)) bus ();

    mul_issue_ctrl #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Expected outputs for the current cycle, maintained by the stimulus.
    logic          e_stall, e_start, e_wbv, e_err;
    logic [DW-1:0] e_a, e_b, e_wbd;
    logic [4:0]    e_wbr;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall",     DW'(bus.stall),     DW'(e_stall));
            check("mul_start", DW'(bus.mul_start), DW'(e_start));
            check("mul_a",     bus.mul_a,          e_a);
            check("mul_b",     bus.mul_b,          e_b);
            check("wb_valid",  DW'(bus.wb_valid),  DW'(e_wbv));
            check("wb_data",   bus.wb_data,        e_wbd);
            check("wb_rd",     DW'(bus.wb_rd),     DW'(e_wbr));
            check("err",       DW'(bus.err),       DW'(e_err));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Reference: the product is simply a*b truncated; the multiplier is only
    // used when neither operand is 0 or 1.
    function automatic logic [DW-1:0] model_prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return a * b;
    endfunction

    function automatic bit uses_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return !(a == 0 || b == 0 || a == 1 || b == 1);
    endfunction

    function automatic logic [DW-1:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return DW'(1);
            default: return DW'($urandom());
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input bit v, input bit m, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [4:0] rd, input bit fl);
        bus.ex_valid  = v;
        bus.ex_is_mul = m;
        bus.ex_op_a   = a;
        bus.ex_op_b   = b;
        bus.ex_rd     = rd;
        bus.flush     = fl;
    endtask

    task automatic set_mul(input bit busy, input bit done, input logic [DW-1:0] res);
        bus.mul_busy   = busy;
        bus.mul_done   = done;
        bus.mul_result = res;
    endtask

    // Cycles with no live MUL request; stray mul_done and flush must be ignored.
    task automatic bubble(input int n);
        repeat (n) begin
            case ($urandom_range(0, 3))
                0:       set_ex(1'b0, 1'($urandom_range(0, 1)), rand_op(), rand_op(), 5'($urandom()), 1'b0);
                1:       set_ex(1'b1, 1'b0, rand_op(), rand_op(), 5'($urandom()), 1'b0);
                2:       set_ex(1'b1, 1'b1, rand_op(), rand_op(), 5'($urandom()), 1'b1);
                default: set_ex(1'b0, 1'b1, rand_op(), rand_op(), 5'($urandom()), 1'b1);
            endcase
            set_mul(1'b0, 1'($urandom_range(0, 1)), DW'($urandom()));
            bus.wb_ready = 1'($urandom_range(0, 1));
            e_stall = 1'b0;
            tick();
        end
    endtask

    // One MUL instruction from request to retirement, with the bench acting
    // as the multiplier (done DW+1 cycles after the start pulse).
    //   bp       : cycles of wb_ready low before the final WB cycle
    //   flush_at : WAIT cycle index of a flush (-1 none)
    //   flush_wb : flush on the final WB cycle
    //   no_done  : multiplier never answers (watchdog)
    //   rst_at   : WAIT cycle index of a reset (-1 none)
    task automatic run_txn(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [4:0] rd,
                           input logic [DW-1:0] exp, input int bp, input int flush_at,
                           input bit flush_wb, input bit no_done, input int rst_at);
        bit drained = 1'b0;
        int last;
        // Request cycle
        set_ex(1'b1, 1'b1, a, b, rd, 1'b0);
        set_mul(1'b0, 1'b0, '0);
        bus.wb_ready = 1'($urandom_range(0, 1));
        e_stall = 1'b1;
        e_start = 1'b0;
        e_wbv   = 1'b0;
        tick();
        e_wbr = rd;
        if (uses_mul(a, b)) begin
            // Start pulse cycle
            set_mul(1'b0, 1'b0, '0);
            bus.wb_ready = 1'($urandom_range(0, 1));
            e_start = 1'b1;
            e_a     = a;
            e_b     = b;
            tick();
            e_start = 1'b0;
            last = no_done ? TMO - 1 : DW;
            for (int k = 0; k <= last; k++) begin
                bus.wb_ready = 1'($urandom_range(0, 1));
                if (k == rst_at) begin
                    set_ex(1'b0, 1'b0, '0, '0, '0, 1'b0);
                    set_mul(1'b1, 1'b0, '0);
                    rst = 1'b1;
                    e_stall = 1'b0;
                    tick();
                    rst = 1'b0;
                    e_a = '0; e_b = '0; e_wbd = '0; e_wbr = '0;
                    e_err = 1'b0; e_wbv = 1'b0; e_start = 1'b0;
                    return;
                end
                if (k == DW && !no_done) set_mul(1'b0, 1'b1, model_prod(a, b));
                else                     set_mul(!no_done, 1'b0, DW'($urandom()));
                if (drained) begin
                    set_ex(1'b1, 1'b1, DW'($urandom()), DW'($urandom()), 5'($urandom()), 1'b0);
                    e_stall = 1'b1;
                end else if (k == flush_at) begin
                    set_ex(1'b1, 1'b1, a, b, rd, 1'b1);
                    e_stall = 1'b0;
                    drained = 1'b1;
                end else begin
                    set_ex(1'b1, 1'b1, a, b, rd, 1'b0);
                    e_stall = 1'b1;
                end
                tick();
            end
            if (no_done) begin
                e_err = 1'b1;
                return;
            end
            if (drained) return;
        end
        // Writeback
        e_wbv = 1'b1;
        e_wbd = exp;
        for (int j = 0; j <= bp; j++) begin
            set_mul(1'b0, 1'($urandom_range(0, 1)), DW'($urandom()));
            if (j < bp) begin
                set_ex(1'b1, 1'b1, a, b, rd, 1'b0);
                bus.wb_ready = 1'b0;
                e_stall = 1'b1;
            end else if (flush_wb) begin
                set_ex(1'b1, 1'b1, a, b, rd, 1'b1);
                bus.wb_ready = 1'($urandom_range(0, 1));
                e_stall = 1'b0;
            end else begin
                set_ex(1'b1, 1'b1, a, b, rd, 1'b0);
                bus.wb_ready = 1'b1;
                e_stall = 1'b0;
            end
            tick();
        end
        e_wbv = 1'b0;
    endtask

    task automatic run_random(input int n);
        logic [DW-1:0] a, b;
        for (int i = 0; i < n; i++) begin
            a = rand_op();
            b = rand_op();
            run_txn(a, b, 5'($urandom()), model_prod(a, b), $urandom_range(0, 3),
                    ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, DW - 1)) : -1,
                    ($urandom_range(0, 5) == 0), 1'b0, -1);
            bubble($urandom_range(0, 2));
        end
    endtask

    initial begin
        rst = 1'b1;
        set_ex(1'b0, 1'b0, '0, '0, '0, 1'b0);
        set_mul(1'b0, 1'b0, '0);
        bus.wb_ready = 1'b0;
        tick();
        e_stall = 1'b0; e_start = 1'b0; e_wbv = 1'b0; e_err = 1'b0;
        e_a = '0; e_b = '0; e_wbd = '0; e_wbr = '0;
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        bubble(2);

        // Directed, with hand-computed products
        run_txn(32'd7, 32'd6, 5'd3, 32'd42, 0, -1, 1'b0, 1'b0, -1);
        bubble(1);
        run_txn(32'h1234, 32'h0, 5'd9, 32'h0, 0, -1, 1'b0, 1'b0, -1);
        run_txn(32'h1, 32'hDEADBEEF, 5'd17, 32'hDEADBEEF, 0, -1, 1'b0, 1'b0, -1);
        run_txn(32'hCAFE, 32'h1, 5'd21, 32'hCAFE, 1, -1, 1'b0, 1'b0, -1);
        run_txn(32'd11, 32'd13, 5'd4, 32'd143, 5, -1, 1'b0, 1'b0, -1);
        bubble(1);
        run_txn(32'd3, 32'd5, 5'd7, 32'd15, 0, 9, 1'b0, 1'b0, -1);
        bubble(2);
        run_txn(32'd2, 32'd3, 5'd1, 32'd6, 2, -1, 1'b1, 1'b0, -1);
        bubble(1);

        run_random(40);

        // Watchdog: err must rise and stay set until reset
        run_txn(32'd9, 32'd9, 5'd2, 32'd81, 0, -1, 1'b0, 1'b1, -1);
        bubble(3);
        run_random(4);

        // Wrap-around, then reset in the middle of a multiply
        run_txn(32'hFFFFFFFF, 32'd2, 5'd30, 32'hFFFFFFFE, 0, -1, 1'b0, 1'b0, -1);
        run_txn(32'hFFFFFFFF, 32'd2, 5'd30, 32'hFFFFFFFE, 0, -1, 1'b0, 1'b0, 10);
        bubble(2);
        run_random(6);
        bubble(1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
